// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the two-requester memory port arbiter:
//   - FSM state encoding (IDLE / ACCESS / DONE)
//   - default memory latency
//   - grant select values used by the address / write-data mux
//   - datapath and latency-counter widths, plus a helper that turns a
//     latency into the terminal count of the ACCESS counter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int LATENCY_DEFAULT = 2;

  // Grant select values: 0 steers the fetch port, 1 the load/store port.
  localparam logic SEL_FETCH = 1'b0;
  localparam logic SEL_LSU   = 1'b1;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  // Terminal value of the ACCESS counter: the counter starts at 0 on the
  // first ACCESS cycle, so the last cycle sees latency-1.
  function automatic logic [CNT_W-1:0] last_cnt(input int latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// mem_port_arbiter_rr_pick2 (the rr_pick2 chooser)
// Combinational two-way round-robin chooser.
// Ports:
//   ReqA  in  1 : request from side A (fetch)
//   ReqB  in  1 : request from side B (load/store)
//   Last  in  1 : side granted most recently (0 = A, 1 = B)
//   Grant out 1 : at least one request is present
//   Pick  out 1 : side to grant (0 = A, 1 = B); only meaningful with Grant
module mem_port_arbiter_rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic ReqA,
  input  logic ReqB,
  input  logic Last,
  output logic Grant,
  output logic Pick
);

  always_comb begin
    Grant = ReqA | ReqB;
    // On a tie the side that did not win last time goes next; otherwise
    // the lone requester wins (B alone -> 1, A alone or none -> 0).
    if (ReqA && ReqB) begin
      Pick = ~Last;
    end else if (ReqB) begin
      Pick = SEL_LSU;
    end else begin
      Pick = SEL_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter for the single 16-bit memory port shared by
// instruction fetch (A) and the load/store unit (B). Grants the port,
// steers address / write data with a registered select, counts a fixed
// memory latency and returns read data with a one-cycle Done pulse.
// Parameters:
//   LATENCY : cycles from MemEn to valid MemRData, 1..15
// Ports:
//   CLK, Reset          : rising-edge clock, synchronous active-high reset
//   ReqA/AddrA/WDataA/WeA : fetch request and operands (held until DoneA)
//   ReqB/AddrB/WDataB/WeB : load/store request and operands (held until DoneB)
//   MemAddr, MemWData   : port address / write data, muxed on Sel
//   MemEn, MemWe        : access strobes, first ACCESS cycle only
//   MemRData            : read data returned by memory
//   Sel                 : registered grant select (0 = A, 1 = B)
//   RData               : registered read data, valid with Done
//   DoneA, DoneB        : one-cycle completion pulses
//   Busy                : high whenever the FSM is not idle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT
)
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ReqA,
  input  logic [DATA_W-1:0] AddrA,
  input  logic [DATA_W-1:0] WDataA,
  input  logic              WeA,
  input  logic              ReqB,
  input  logic [DATA_W-1:0] AddrB,
  input  logic [DATA_W-1:0] WDataB,
  input  logic              WeB,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemEn,
  output logic              MemWe,
  input  logic [DATA_W-1:0] MemRData,
  output logic              Sel,
  output logic [DATA_W-1:0] RData,
  output logic              DoneA,
  output logic              DoneB,
  output logic              Busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = last_cnt(LATENCY);

  state_t              state_reg;
  state_t              state_next;
  logic                sel_reg;
  logic                last_reg;
  logic                we_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                grant;
  logic                pick;
  logic                cnt_done;

  mem_port_arbiter_rr_pick2 u_rr_pick2 (
    .ReqA  (ReqA),
    .ReqB  (ReqB),
    .Last  (last_reg),
    .Grant (grant),
    .Pick  (pick)
  );

  assign cnt_done = (cnt_reg == CNT_LAST);

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant) state_next = ACCESS;
      ACCESS:  if (cnt_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, latency counter and read-data registers. Sel only moves on the
  // edge leaving IDLE, so it is stable for the whole ACCESS/DONE span.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      sel_reg   <= SEL_FETCH;
      last_reg  <= SEL_LSU;     // makes A win the first tie
      we_reg    <= 1'b0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            sel_reg  <= pick;
            last_reg <= pick;
            we_reg   <= (pick == SEL_LSU) ? WeB : WeA;
            cnt_reg  <= '0;
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg + 1'b1;
          // With LATENCY=1 this fires in the single ACCESS cycle.
          if (cnt_done) rdata_reg <= MemRData;
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    MemEn = 1'b0;
    MemWe = 1'b0;
    DoneA = 1'b0;
    DoneB = 1'b0;
    Busy  = 1'b0;
    case (state_reg)
      ACCESS: begin
        Busy = 1'b1;
        if (cnt_reg == '0) begin
          MemEn = 1'b1;
          MemWe = we_reg;
        end
      end
      DONE: begin
        Busy  = 1'b1;
        DoneA = (sel_reg == SEL_FETCH);
        DoneB = (sel_reg == SEL_LSU);
      end
      default: ;
    endcase
  end

  // Port muxes are live in every state; memory only acts on MemEn.
  assign MemAddr  = (sel_reg == SEL_LSU) ? AddrB  : AddrA;
  assign MemWData = (sel_reg == SEL_LSU) ? WDataB : WDataA;
  assign Sel      = sel_reg;
  assign RData    = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter: a LATENCY=2 instance driven by
// a vector table and hand-written sequences, plus a LATENCY=1 instance for
// back-to-back fetches. Completions are matched against a scoreboard queue.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- LATENCY=2 instance ----------------
  logic        reset;
  logic        reqa, wea, reqb, web;
  logic [15:0] addra, wdataa, addrb, wdatab;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, mem_rdata_drv, rdata;
  logic        mem_en, mem_we, sel, done_a, done_b, busy;
  logic        model_on;

  // Simple memory model: read data is a fixed scramble of the address.
  assign mem_rdata = model_on ? (mem_addr ^ 16'hA5C3) : mem_rdata_drv;

  mem_port_arbiter #(.LATENCY(2)) dut (
    .CLK(clk), .Reset(reset),
    .ReqA(reqa), .AddrA(addra), .WDataA(wdataa), .WeA(wea),
    .ReqB(reqb), .AddrB(addrb), .WDataB(wdatab), .WeB(web),
    .MemAddr(mem_addr), .MemWData(mem_wdata), .MemEn(mem_en), .MemWe(mem_we),
    .MemRData(mem_rdata), .Sel(sel), .RData(rdata),
    .DoneA(done_a), .DoneB(done_b), .Busy(busy)
  );

  // ---------------- LATENCY=1 instance ----------------
  logic        reqa1;
  logic [15:0] addra1, mem_rdata1, mem_addr1, mem_wdata1, rdata1;
  logic        mem_en1, mem_we1, sel1, done_a1, done_b1, busy1;

  mem_port_arbiter #(.LATENCY(1)) dut1 (
    .CLK(clk), .Reset(reset),
    .ReqA(reqa1), .AddrA(addra1), .WDataA(16'h3C3C), .WeA(1'b0),
    .ReqB(1'b0), .AddrB(16'h0000), .WDataB(16'h0000), .WeB(1'b0),
    .MemAddr(mem_addr1), .MemWData(mem_wdata1), .MemEn(mem_en1), .MemWe(mem_we1),
    .MemRData(mem_rdata1), .Sel(sel1), .RData(rdata1),
    .DoneA(done_a1), .DoneB(done_b1), .Busy(busy1)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        who;    // 0 = A, 1 = B
    logic        chk;    // compare read data
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] sb1_q[$];

  function automatic exp_t mk_exp(input logic who, input logic chk, input logic [15:0] data);
    exp_t e;
    e.who  = who;
    e.chk  = chk;
    e.data = data;
    return e;
  endfunction

  always @(negedge clk) begin : mon_l2
    exp_t e;
    if (done_a || done_b) begin
      if (sb_q.size() == 0) begin
        check("done_unexpected", {30'd0, done_a, done_b}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("done: who=%0d rdata=%04h", done_b, rdata);
        check("done_who", {31'd0, done_b}, {31'd0, e.who});
        check("done_onehot", {31'd0, done_a & done_b}, 32'd0);
        if (e.chk) check("done_rdata", {16'd0, rdata}, {16'd0, e.data});
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        use_b;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdata;
    logic        exp_sel;
    int          exp_we_cnt;
    int          exp_done_cyc;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int   en_cyc, en_cnt, we_cnt, done_cyc, ndone, cnt, k, last_done;
    logic found;
    logic sel_grant;

    reset = 1'b1;
    reqa = 0; wea = 0; addra = 0; wdataa = 0;
    reqb = 0; web = 0; addrb = 0; wdatab = 0;
    model_on = 0; mem_rdata_drv = 0;
    reqa1 = 0; addra1 = 16'h0800; mem_rdata1 = 0;

    vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0, 0, 3};
    vecs[1] = '{1'b1, 1'b1, 16'h0100, 16'h1234, 16'hDEAD, 1'b1, 1, 3};
    vecs[2] = '{1'b1, 1'b0, 16'h0200, 16'h0F0F, 16'h5A5A, 1'b1, 0, 3};
    vecs[3] = '{1'b0, 1'b1, 16'h0300, 16'hABCD, 16'h0001, 1'b0, 1, 3};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h7777, 16'h8001, 1'b0, 0, 3};

    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_memen", {31'd0, mem_en}, 32'd0);
    check("rst_memwe", {31'd0, mem_we}, 32'd0);
    check("rst_done",  {30'd0, done_a, done_b}, 32'd0);
    check("rst_sel",   {31'd0, sel}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_busy_l1", {31'd0, busy1}, 32'd0);
    reset = 1'b0;

    // First tie after reset goes to A
    reqa = 1; reqb = 1; addra = 16'h1111; addrb = 16'h2222; model_on = 1;
    sb_q.push_back(mk_exp(1'b0, 1'b1, 16'h1111 ^ 16'hA5C3));
    found = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_a || done_b) begin found = 1; break; end
    end
    reqa = 0; reqb = 0;
    check("first_tie_done", {31'd0, found}, 32'd1);
    @(negedge clk);

    // Table-driven single transactions
    model_on = 0;
    for (int i = 0; i < 5; i++) begin
      reqa   = !vecs[i].use_b;
      reqb   =  vecs[i].use_b;
      addra  = vecs[i].use_b ? ~vecs[i].addr  : vecs[i].addr;
      addrb  = vecs[i].use_b ?  vecs[i].addr  : ~vecs[i].addr;
      wdataa = vecs[i].use_b ? ~vecs[i].wdata : vecs[i].wdata;
      wdatab = vecs[i].use_b ?  vecs[i].wdata : ~vecs[i].wdata;
      wea    = vecs[i].use_b ? ~vecs[i].we : vecs[i].we;
      web    = vecs[i].use_b ?  vecs[i].we : ~vecs[i].we;
      mem_rdata_drv = vecs[i].mdata;
      sb_q.push_back(mk_exp(vecs[i].use_b, !vecs[i].we, vecs[i].mdata));
      en_cyc = -1; en_cnt = 0; we_cnt = 0; done_cyc = -1;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (mem_en) begin
          en_cnt++;
          if (en_cyc < 0) begin
            en_cyc = c;
            check("vec_memaddr",  {16'd0, mem_addr},  {16'd0, vecs[i].addr});
            check("vec_memwdata", {16'd0, mem_wdata}, {16'd0, vecs[i].wdata});
            check("vec_sel",      {31'd0, sel},       {31'd0, vecs[i].exp_sel});
          end
        end
        if (mem_we) we_cnt++;
        if (done_a || done_b) begin
          done_cyc = c;
          check("vec_sel_done", {31'd0, sel}, {31'd0, vecs[i].exp_sel});
          break;
        end
      end
      reqa = 0; reqb = 0;
      check("vec_en_cycle", en_cyc,   1);
      check("vec_en_count", en_cnt,   1);
      check("vec_we_count", we_cnt,   vecs[i].exp_we_cnt);
      check("vec_done_cyc", done_cyc, vecs[i].exp_done_cyc);
      @(negedge clk);
      check("vec_idle_after", {31'd0, busy}, 32'd0);
    end

    // Reset in the middle of a B write, then contention
    reqb = 1; web = 1; addrb = 16'h0100; wdatab = 16'h1234;
    found = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_en) begin found = 1; break; end
    end
    check("rstmid_reached_access", {31'd0, found}, 32'd1);
    reset = 1; reqa = 1; wea = 0; web = 0; addra = 16'h1111; addrb = 16'h2222; model_on = 1;
    @(negedge clk);
    check("rstmid_busy",  {31'd0, busy},   32'd0);
    check("rstmid_memen", {31'd0, mem_en}, 32'd0);
    check("rstmid_doneb", {31'd0, done_b}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back(mk_exp(i[0], 1'b1, (i[0] ? 16'h2222 : 16'h1111) ^ 16'hA5C3));
    end
    reset = 0;
    ndone = 0; sel_grant = 0;
    for (int c = 0; c < 80 && ndone < 8; c++) begin
      @(negedge clk);
      if (mem_en) sel_grant = sel;
      else if (busy) check("contention_sel_stable", {31'd0, sel}, {31'd0, sel_grant});
      if (done_a || done_b) ndone++;
    end
    reqa = 0; reqb = 0;
    check("contention_count", ndone, 8);
    @(negedge clk);
    check("contention_sb_empty", sb_q.size(), 0);

    // ReqA dropped during the second ACCESS cycle
    reqa = 1; addra = 16'h0500;
    sb_q.push_back(mk_exp(1'b0, 1'b1, 16'h0500 ^ 16'hA5C3));
    found = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_en) begin found = 1; break; end
    end
    check("drop_reached_access", {31'd0, found}, 32'd1);
    @(negedge clk);
    reqa = 0;
    found = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done_a) begin found = 1; break; end
    end
    check("drop_done_a", {31'd0, found}, 32'd1);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("drop_then_idle", cnt, 0);

    // LATENCY=1 back-to-back fetches
    reqa1 = 1;
    ndone = 0; k = 0; last_done = -1; cnt = 0;
    for (int c = 0; c < 40 && ndone < 5; c++) begin
      @(negedge clk);
      if (done_b1) cnt++;
      if (done_a1) begin
        if (sb1_q.size() == 0) begin
          check("l1_done_unexpected", {31'd0, done_a1}, 32'd0);
        end else begin
          $display("l1 done: rdata=%04h", rdata1);
          check("l1_rdata", {16'd0, rdata1}, {16'd0, sb1_q.pop_front()});
        end
        if (last_done >= 0) check("l1_period", c - last_done, 3);
        check("l1_busy_done", {31'd0, busy1}, 32'd1);
        last_done = c;
        ndone++;
        if (ndone == 5) reqa1 = 0;
      end
      if (mem_en1) begin
        check("l1_memaddr", {16'd0, mem_addr1}, 32'h0800);
        check("l1_memwdata", {16'd0, mem_wdata1}, 32'h3C3C);
        check("l1_memwe_sel", {30'd0, mem_we1, sel1}, 32'd0);
        mem_rdata1 = 16'hC000 + 16'(k * 16'h0111);
        sb1_q.push_back(mem_rdata1);
        k++;
      end
    end
    check("l1_count", ndone, 5);
    check("l1_no_doneb", cnt, 0);
    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
